multi_string_matcher: RTL and testbench
=======================================

# multi_string_matcher

Parametrised multi-pattern string matcher for the Ethernet sniffer datapath. It replaces the single-pattern, fixed-width comparator. It holds NUM_PATTERNS independently programmable flagged strings, checks every byte alignment of a streaming BUS_BYTES-wide payload against all of them, and reports a per-pattern match vector plus a priority index. Payload passes through with fixed latency, so downstream logic can tag or drop the frame.

## Interface
- BUS_BYTES, 4: payload bytes per word.
- MAX_LEN, 17: maximum pattern length in bytes.
- NUM_PATTERNS, 4: number of pattern slots.
- STICKY, 1: 1 = match bits hold until clear; 0 = single-cycle pulse per hit.
- Derived: DEPTH = ceil((MAX_LEN+BUS_BYTES-1)/BUS_BYTES) window words; IW = max(1,$clog2(NUM_PATTERNS)); LW = $clog2(MAX_LEN+1).
- clk  in  1  clock.
- n_rst  in  1  reset, asynchronous, active-low.
- clear  in  1  synchronous frame clear.
- in_valid  in  1  data_in holds a payload word this cycle.
- data_in  in  8*BUS_BYTES  payload; bits [8*BUS_BYTES-1 -: 8] are earliest on the wire.
- cfg_we  in  1  write one pattern slot.
- cfg_idx  in  IW  slot written.
- cfg_len  in  LW  pattern length; 0 disables slot.
- cfg_pattern  in  8*MAX_LEN  byte i (first char i=0) at [8*i +: 8].
- out_valid  out  1  data_out is a delayed valid word.
- data_out  out  8*BUS_BYTES  payload delayed DEPTH accepted words.
- match_vec  out  NUM_PATTERNS  per-slot hit.
- match  out  1  OR of match_vec.
- match_idx  out  IW  lowest set bit of match_vec; 0 when none.

## Operation
- Window: DEPTH-word shift register plus one byte-valid bit per byte. It shifts only on in_valid. Byte-valid bits keep reset/cleared bytes from matching zero-valued pattern bytes.
- Per slot, per alignment a in 0..BUS_BYTES-1: hit if the last cfg_len window bytes ending at byte offset a of the newest word equal pattern bytes 0..cfg_len-1 in wire order, and all those bytes are valid. Slot hit = OR over alignments.
- Evaluation is enabled only the cycle after a shift (registered in_valid).
- STICKY=1: match_vec[k] sets on hit and holds until clear, reset, or a cfg write to slot k. STICKY=0: match_vec = hit & eval enable.
- Config: on cfg_we, slot cfg_idx gets cfg_len/cfg_pattern. cfg_len > MAX_LEN or cfg_idx >= NUM_PATTERNS: write ignored. Config survives clear; reset zeroes all slots, which disables them.
- clear: empties the window (data and valid bits), drops out_valid and match_vec, and ignores that cycle's in_valid. The cfg write in the same cycle still applies.
- Simultaneous cfg write and hit on the same slot: the write wins, and the bit is 0 next cycle.

## Timing
- Reset: all outputs 0, window empty, all slots disabled.
- Word accepted at edge k, completing a pattern: match_vec rises at edge k+1 (1-cycle latency from window update).
- data_out/out_valid: word accepted at edge k appears after DEPTH further accepted words, at the edge that accepts the DEPTH-th. out_valid follows that word's valid bit.
- A new pattern takes effect from the first evaluation after its write edge.
- Reset mid-frame: immediate async clear. The first frame after reset must be reprogrammed.

## Structure
- Package sniffer_pkg: BUS_BYTES/MAX_LEN defaults and a pattern_cfg_t struct {len, bytes}.
- Sub-module pattern_slot: holds one config and its sticky bit, and computes the alignment hits from the shared window. Instantiated NUM_PATTERNS times by generate.
- Top: window shift register, valid tracking, priority encoder.

## Test plan
- Slot 0 = "EVIL" (len 4). Stream 0x00EVIL_XX across a word boundary -> match_vec=0001 one cycle after the completing word; match_idx=0.
- Slot 2 = 17-byte string straddling 5 words, at each of 4 alignments -> hit each time. Same string with the last byte changed -> no hit.
- Slot 1 = 0x00000000 (len 4); zeros stream after reset/clear, before 4 real zero bytes -> no hit until the 4th real zero byte.
- Slots 1 and 3 hit in the same word -> match_vec=1010, match_idx=1. STICKY=0 build -> 1-cycle pulse only.
- in_valid gaps: 8 words with bubbles -> data_out sequence unchanged, each word emitted after DEPTH=5 accepts, out_valid only on those edges.
- clear together with a hit, and cfg write to the matched slot -> match_vec=0 next cycle; config retained after clear; write with cfg_len=18 ignored.

Source files
------------

// File: rtl/sniffer_pkg.sv
// rtl/sniffer_pkg.sv - shared defaults, pattern config type and sizing helper for the string matcher
//
// Purpose: default payload width and pattern length for the sniffer matcher,
// the per-slot configuration record, and the window depth calculation.
// Ports: none (package).
package sniffer_pkg;

  localparam int DEF_BUS_BYTES = 4;
  localparam int DEF_MAX_LEN   = 17;
  localparam int DEF_LEN_W     = $clog2(DEF_MAX_LEN + 1);

  // One pattern slot: length (0 = disabled) and bytes, first char in [7:0].
  typedef struct packed {
    logic [DEF_LEN_W-1:0]     len;
    logic [8*DEF_MAX_LEN-1:0] bytes;
  } pattern_cfg_t;

  // Words needed so a max-length pattern ending at any alignment of the
  // newest word still fits: ceil((max_len + bus_bytes - 1) / bus_bytes).
  function automatic int window_depth(input int bus_bytes, input int max_len);
    return (max_len + 2 * bus_bytes - 2) / bus_bytes;
  endfunction

endpackage

// File: rtl/multi_string_matcher_if.sv
// rtl/multi_string_matcher_if.sv - payload, config and match-report bundle for the string matcher
//
// Purpose: groups the matcher's stream, config and result signals.
// Ports (slave = matcher side):
//   clear, in_valid, data_in, cfg_we, cfg_idx, cfg_len, cfg_pattern : into matcher
//   out_valid, data_out, match_vec, match, match_idx                 : out of matcher
interface multi_string_matcher_if #(
  parameter int BUS_BYTES    = 4,
  parameter int MAX_LEN      = 17,
  parameter int NUM_PATTERNS = 4
);
  localparam int IW = (NUM_PATTERNS > 1) ? $clog2(NUM_PATTERNS) : 1;
  localparam int LW = $clog2(MAX_LEN + 1);

  logic                    clear;
  logic                    in_valid;
  logic [8*BUS_BYTES-1:0]  data_in;
  logic                    cfg_we;
  logic [IW-1:0]           cfg_idx;
  logic [LW-1:0]           cfg_len;
  logic [8*MAX_LEN-1:0]    cfg_pattern;
  logic                    out_valid;
  logic [8*BUS_BYTES-1:0]  data_out;
  logic [NUM_PATTERNS-1:0] match_vec;
  logic                    match;
  logic [IW-1:0]           match_idx;

  modport master (
    output clear, in_valid, data_in, cfg_we, cfg_idx, cfg_len, cfg_pattern,
    input  out_valid, data_out, match_vec, match, match_idx
  );

  modport slave (
    input  clear, in_valid, data_in, cfg_we, cfg_idx, cfg_len, cfg_pattern,
    output out_valid, data_out, match_vec, match, match_idx
  );

endinterface

// File: rtl/pattern_slot.sv
// rtl/pattern_slot.sv - one programmable pattern slot with its match bit
//
// Purpose: stores one pattern config and checks it against the shared window
// at every byte alignment of the newest word.
// Ports:
//   clk, n_rst        clock, async active-low reset (clears config -> slot disabled)
//   clear             frame clear (drops the match bit, keeps config)
//   eval_en           window shifted last edge; hits count only then
//   wr_en, wr_cfg     accepted config write for this slot
//   win_data, win_bv  window bytes, byte 0 = newest (last on wire), with valid bits
//   match_bit         registered hit (sticky or pulse)
module pattern_slot
  import sniffer_pkg::*;
#(
  parameter int BUS_BYTES = DEF_BUS_BYTES,
  parameter int MAX_LEN   = DEF_MAX_LEN,
  parameter int NB        = BUS_BYTES * window_depth(BUS_BYTES, MAX_LEN),
  parameter bit STICKY    = 1'b1
) (
  input  logic            clk,
  input  logic            n_rst,
  input  logic            clear,
  input  logic            eval_en,
  input  logic            wr_en,
  input  pattern_cfg_t    wr_cfg,
  input  logic [8*NB-1:0] win_data,
  input  logic [NB-1:0]   win_bv,
  output logic            match_bit
);

  pattern_cfg_t cfg_q;
  logic         hit;
  logic         align_ok;

  // Alignment a ends on window byte e = BUS_BYTES-1-a; the byte q places
  // further back must equal pattern byte len-1-q.
  always_comb begin
    hit      = 1'b0;
    align_ok = 1'b0;
    for (int a = 0; a < BUS_BYTES; a++) begin
      align_ok = (cfg_q.len != '0);
      for (int q = 0; q < MAX_LEN; q++) begin
        if (q < int'(cfg_q.len)) begin
          if (!win_bv[BUS_BYTES-1-a+q] ||
              (win_data[8*(BUS_BYTES-1-a+q) +: 8] !=
               cfg_q.bytes[8*(int'(cfg_q.len)-1-q) +: 8])) begin
            align_ok = 1'b0;
          end
        end
      end
      hit = hit | align_ok;
    end
  end

  // A write to this slot beats a simultaneous hit.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      cfg_q     <= '0;
      match_bit <= 1'b0;
    end else begin
      if (wr_en) begin
        cfg_q <= wr_cfg;
      end
      if (clear || wr_en) begin
        match_bit <= 1'b0;
      end else if (STICKY) begin
        if (hit && eval_en) begin
          match_bit <= 1'b1;
        end
      end else begin
        match_bit <= hit && eval_en;
      end
    end
  end

endmodule

// File: rtl/multi_string_matcher.sv
// rtl/multi_string_matcher.sv - multi-pattern streaming string matcher with fixed-latency pass-through
//
// Purpose: keeps a DEPTH-word window of the payload, checks all pattern slots
// against it after every shift, and passes the payload through DEPTH accepted
// words later.
// Ports:
//   clk, n_rst   clock, async active-low reset
//   bus (slave)  clear/in_valid/data_in, cfg_we/cfg_idx/cfg_len/cfg_pattern in;
//                out_valid/data_out, match_vec/match/match_idx out
module multi_string_matcher
  import sniffer_pkg::*;
#(
  parameter int BUS_BYTES    = DEF_BUS_BYTES,
  parameter int MAX_LEN      = DEF_MAX_LEN,
  parameter int NUM_PATTERNS = 4,
  parameter bit STICKY       = 1'b1
) (
  input logic                   clk,
  input logic                   n_rst,
  multi_string_matcher_if.slave bus
);

  localparam int DEPTH = window_depth(BUS_BYTES, MAX_LEN);
  localparam int NB    = DEPTH * BUS_BYTES;
  localparam int WW    = 8 * BUS_BYTES;
  localparam int IW    = (NUM_PATTERNS > 1) ? $clog2(NUM_PATTERNS) : 1;
  localparam int LW    = $clog2(MAX_LEN + 1);

  // Newest word in the low bits; oldest word leaves from the top.
  logic [8*NB-1:0]         win_data;
  logic [NB-1:0]           win_bv;
  logic                    eval_en;
  logic                    out_valid_q;
  logic [WW-1:0]           data_out_q;
  logic [NUM_PATTERNS-1:0] match_q;
  logic [IW-1:0]           match_idx_c;
  logic                    len_ok;
  pattern_cfg_t            wr_cfg;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      win_data    <= '0;
      win_bv      <= '0;
      eval_en     <= 1'b0;
      out_valid_q <= 1'b0;
      data_out_q  <= '0;
    end else if (bus.clear) begin
      win_data    <= '0;
      win_bv      <= '0;
      eval_en     <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      eval_en     <= bus.in_valid;
      out_valid_q <= 1'b0;
      if (bus.in_valid) begin
        win_data    <= {win_data[8*NB-WW-1:0], bus.data_in};
        win_bv      <= {win_bv[NB-BUS_BYTES-1:0], {BUS_BYTES{1'b1}}};
        data_out_q  <= win_data[8*NB-1 -: WW];
        out_valid_q <= win_bv[NB-1];
      end
    end
  end

  assign len_ok       = (bus.cfg_len <= LW'(MAX_LEN));
  assign wr_cfg.len   = bus.cfg_len;
  assign wr_cfg.bytes = bus.cfg_pattern;

  // Out-of-range slot indices decode to no slot, so they are dropped here.
  for (genvar k = 0; k < NUM_PATTERNS; k++) begin : g_slot
    pattern_slot #(
      .BUS_BYTES (BUS_BYTES),
      .MAX_LEN   (MAX_LEN),
      .NB        (NB),
      .STICKY    (STICKY)
    ) u_slot (
      .clk       (clk),
      .n_rst     (n_rst),
      .clear     (bus.clear),
      .eval_en   (eval_en),
      .wr_en     (bus.cfg_we && len_ok && (bus.cfg_idx == IW'(k))),
      .wr_cfg    (wr_cfg),
      .win_data  (win_data),
      .win_bv    (win_bv),
      .match_bit (match_q[k])
    );
  end

  // Lowest set slot wins.
  always_comb begin
    match_idx_c = '0;
    for (int k = NUM_PATTERNS - 1; k >= 0; k--) begin
      if (match_q[k]) begin
        match_idx_c = IW'(k);
      end
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.data_out  = data_out_q;
  assign bus.match_vec = match_q;
  assign bus.match     = |match_q;
  assign bus.match_idx = match_idx_c;

endmodule

// File: tb/tb_multi_string_matcher.sv
// tb/tb_multi_string_matcher.sv - scoreboard bench for sticky and pulse matcher builds
module tb_multi_string_matcher;

  localparam int BB    = 4;
  localparam int ML    = 17;
  localparam int NP    = 4;
  localparam int DEPTH = 5;

  typedef struct packed {
    logic        ov;
    logic [31:0] dout;
    logic [3:0]  stk;
    logic [3:0]  pls;
  } exp_t;

  logic clk   = 1'b0;
  logic n_rst = 1'b0;
  always #5 clk = ~clk;

  multi_string_matcher_if #(.BUS_BYTES(BB), .MAX_LEN(ML), .NUM_PATTERNS(NP)) bus1 ();
  multi_string_matcher_if #(.BUS_BYTES(BB), .MAX_LEN(ML), .NUM_PATTERNS(NP)) bus0 ();

  assign bus0.clear       = bus1.clear;
  assign bus0.in_valid    = bus1.in_valid;
  assign bus0.data_in     = bus1.data_in;
  assign bus0.cfg_we      = bus1.cfg_we;
  assign bus0.cfg_idx     = bus1.cfg_idx;
  assign bus0.cfg_len     = bus1.cfg_len;
  assign bus0.cfg_pattern = bus1.cfg_pattern;

  multi_string_matcher #(.BUS_BYTES(BB), .MAX_LEN(ML), .NUM_PATTERNS(NP), .STICKY(1'b1))
    dut_s (.clk(clk), .n_rst(n_rst), .bus(bus1));
  multi_string_matcher #(.BUS_BYTES(BB), .MAX_LEN(ML), .NUM_PATTERNS(NP), .STICKY(1'b0))
    dut_p (.clk(clk), .n_rst(n_rst), .bus(bus0));

  int          checks   = 0;
  int          failures = 0;
  exp_t        q[$];
  logic [31:0] shadow[$];
  logic [3:0]  pend = 4'b0;
  logic [3:0]  stk  = 4'b0;
  string       pat17 = "ABCDEFGHIJKLMNOPQ";

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [1:0] low_idx(input logic [3:0] v);
    for (int k = 0; k < 4; k++) if (v[k]) return 2'(k);
    return 2'd0;
  endfunction

  function automatic logic [8*ML-1:0] pat_str(input string s);
    logic [8*ML-1:0] r;
    r = '0;
    for (int i = 0; i < s.len(); i++) r[8*i +: 8] = s[i];
    return r;
  endfunction

  task automatic set_cfg(input logic [1:0] idx, input logic [4:0] len, input logic [8*ML-1:0] pat);
    bus1.cfg_we      = 1'b1;
    bus1.cfg_idx     = idx;
    bus1.cfg_len     = len;
    bus1.cfg_pattern = pat;
  endtask

  // h = slots the word sent in this cycle completes (visible two edges later).
  task automatic step(input logic v, input logic [31:0] d, input logic clr, input logic [3:0] h);
    exp_t       e;
    logic [3:0] wm;
    wm = 4'b0;
    if (bus1.cfg_we && bus1.cfg_len <= 5'd17) wm[bus1.cfg_idx] = 1'b1;
    e.pls  = clr ? 4'b0 : (pend & ~wm);
    stk    = clr ? 4'b0 : ((stk | pend) & ~wm);
    e.stk  = stk;
    e.ov   = 1'b0;
    e.dout = 32'h0;
    if (clr) shadow.delete();
    else if (v) begin
      if (shadow.size() == DEPTH) begin
        e.ov   = 1'b1;
        e.dout = shadow.pop_front();
      end
      shadow.push_back(d);
    end
    pend = (v && !clr) ? h : 4'b0;
    bus1.in_valid = v;
    bus1.data_in  = d;
    bus1.clear    = clr;
    @(posedge clk);
    q.push_back(e);
    #1;
    bus1.cfg_we   = 1'b0;
    bus1.in_valid = 1'b0;
    bus1.clear    = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 32'h0, 1'b0, 4'b0);
  endtask

  task automatic do_clear();
    step(1'b0, 32'h0, 1'b1, 4'b0);
  endtask

  task automatic send_str(input string s, input logic [3:0] last_hit);
    string t;
    int    nw;
    t = s;
    while (t.len() % 4 != 0) t = {t, "."};
    nw = t.len() / 4;
    for (int w = 0; w < nw; w++)
      step(1'b1, {t[4*w], t[4*w+1], t[4*w+2], t[4*w+3]}, 1'b0,
           (w == nw - 1) ? last_hit : 4'b0);
  endtask

  task automatic send_evil(input logic [3:0] h);
    step(1'b1, {8'h00, 8'h00, "E", "V"}, 1'b0, 4'b0);
    step(1'b1, {"I", "L", "X", "X"}, 1'b0, h);
  endtask

  // Monitor: one expectation per driven cycle, checked mid-cycle.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        e = q.pop_front();
        check("match_vec_sticky", bus1.match_vec, e.stk);
        check("match_sticky", bus1.match, |e.stk);
        check("match_idx_sticky", bus1.match_idx, low_idx(e.stk));
        check("match_vec_pulse", bus0.match_vec, e.pls);
        check("out_valid", bus1.out_valid, e.ov);
        if (e.ov) check("data_out", bus1.data_out, e.dout);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    string s;
    bus1.clear = 1'b0; bus1.in_valid = 1'b0; bus1.data_in = '0;
    bus1.cfg_we = 1'b0; bus1.cfg_idx = '0; bus1.cfg_len = '0; bus1.cfg_pattern = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_match_vec", bus1.match_vec, 4'b0);
    check("reset_match", bus1.match, 1'b0);
    check("reset_match_idx", bus1.match_idx, 2'd0);
    check("reset_out_valid", bus1.out_valid, 1'b0);
    check("reset_data_out", bus1.data_out, 32'h0);
    check("reset_pulse_vec", bus0.match_vec, 4'b0);
    @(posedge clk); #1;
    n_rst = 1'b1;

    // "EVIL" across a word boundary
    set_cfg(2'd0, 5'd4, pat_str("EVIL"));
    idle(1);
    send_evil(4'b0001);
    idle(3);
    do_clear();

    // 17-byte pattern at each alignment, then a near miss
    set_cfg(2'd2, 5'd17, pat_str(pat17));
    idle(1);
    for (int p = 0; p < 4; p++) begin
      s = "";
      for (int i = 0; i < p; i++) s = {s, "."};
      s = {s, pat17};
      send_str(s, 4'b0100);
      idle(1);
      do_clear();
    end
    send_str(".ABCDEFGHIJKLMNOPZ", 4'b0000);
    idle(1);
    do_clear();

    // all-zero pattern must not match cleared window bytes
    set_cfg(2'd1, 5'd4, '0);
    idle(1);
    step(1'b1, {"x", 8'h00, 8'h00, 8'h00}, 1'b0, 4'b0000);
    step(1'b1, {8'h00, "y", "y", "y"}, 1'b0, 4'b0010);
    idle(2);
    do_clear();

    // slots 1 and 3 in the same word; slot 3 written on that word's edge
    step(1'b1, {"W", "X", 8'h00, 8'h00}, 1'b0, 4'b0000);
    set_cfg(2'd3, 5'd2, pat_str("YZ"));
    step(1'b1, {8'h00, 8'h00, "Y", "Z"}, 1'b0, 4'b1010);
    idle(2);
    do_clear();

    // pass-through with bubbles
    for (int i = 0; i < 13; i++) begin
      step(1'b1, {8'hA0 + 8'(i), 8'hB1, 8'hC2, 8'hD3}, 1'b0, 4'b0);
      idle(i % 3);
    end
    do_clear();
    idle(1);

    // clear on the evaluation cycle of a hit
    send_evil(4'b0001);
    do_clear();
    idle(1);

    // cfg write to the matched slot on its evaluation cycle
    send_evil(4'b0001);
    set_cfg(2'd0, 5'd4, pat_str("EVIL"));
    idle(2);

    // hit again, then an oversized write that must be ignored
    send_evil(4'b0001);
    idle(1);
    set_cfg(2'd0, 5'd18, pat_str("ZZZZ"));
    idle(2);
    do_clear();
    send_evil(4'b0001);
    idle(2);

    @(negedge clk);
    #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
